// File: rtl/signal_phase_controller_if.sv
// Detector, push-button and lamp-driver signal bundle for signal_phase_controller.
// The master side drives requests and detects; the slave side is the controller.
interface signal_phase_controller_if #(
    parameter int unsigned NUM_PHASES = 4
);
    logic                  flash_req;
    logic [NUM_PHASES-1:0] veh_present;
    logic [NUM_PHASES-1:0] ped_req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] ped_walk;
    logic [2:0]            active_phase;
    logic                  in_flash;

    modport master (
        output flash_req, veh_present, ped_req,
        input  red, yellow, green, ped_walk, active_phase, in_flash
    );

    modport slave (
        input  flash_req, veh_present, ped_req,
        output red, yellow, green, ped_walk, active_phase, in_flash
    );
endinterface

// File: rtl/signal_phase_controller.sv
// N-phase traffic signal controller: green/yellow/all-red rotation with demand
// skipping, rest-in-green, pedestrian WALK and red-flash mode.
module signal_phase_controller #(
    parameter int unsigned NUM_PHASES   = 4,
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned GREEN_TICKS  = 10,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 5,
    parameter int unsigned TIMER_W      = 32
) (
    input logic clk,
    input logic rst,
    signal_phase_controller_if.slave ctl
);
    typedef enum logic [1:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_t;

    state_t                state, state_nx;
    logic [2:0]            active_phase, active_nx;
    logic [2:0]            next_phase, next_nx;
    logic [TIMER_W-1:0]    prescaler, timer;
    logic [NUM_PHASES-1:0] ped_pending, ped_clr, demand, phase_oh, demand_sh;
    logic                  flash_on, walk_en, tick, entering_green, found;
    logic [2:0]            found_idx;
    int unsigned           idx;

    assign tick           = (prescaler == TIMER_W'(TICK_DIV - 1));
    assign demand         = ctl.veh_present | ped_pending;
    assign phase_oh       = NUM_PHASES'(1) << active_phase;
    assign entering_green = (state == ST_ALL_RED) && (state_nx == ST_GREEN);
    assign ped_clr        = entering_green ? (NUM_PHASES'(1) << next_phase) : '0;

    // Round-robin search from the phase after the active one; the active phase
    // itself is never a candidate, so its own latched ped call cannot end it.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        idx       = 0;
        demand_sh = '0;
        for (int unsigned k = 1; k < NUM_PHASES; k++) begin
            idx       = (32'(active_phase) + k) % NUM_PHASES;
            demand_sh = demand >> idx;
            if (!found && demand_sh[0]) begin
                found     = 1'b1;
                found_idx = idx[2:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        next_nx   = next_phase;
        active_nx = active_phase;
        case (state)
            ST_ALL_RED: begin
                if (tick && timer == TIMER_W'(ALLRED_TICKS - 1)) begin
                    if (ctl.flash_req) begin
                        state_nx = ST_FLASH;
                    end else begin
                        state_nx  = ST_GREEN;
                        active_nx = next_phase;
                    end
                end
            end
            ST_GREEN: begin
                if (tick) begin
                    if (ctl.flash_req) begin
                        state_nx = ST_YELLOW;
                    end else if (timer >= TIMER_W'(GREEN_TICKS - 1) && found) begin
                        state_nx = ST_YELLOW;
                        next_nx  = found_idx;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick && timer == TIMER_W'(YELLOW_TICKS - 1)) begin
                    state_nx = ST_ALL_RED;
                end
            end
            ST_FLASH: begin
                if (!ctl.flash_req) begin
                    state_nx = ST_ALL_RED;
                    next_nx  = '0;
                end
            end
            default: state_nx = ST_ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ALL_RED;
            active_phase <= '0;
            next_phase   <= '0;
            prescaler    <= '0;
            timer        <= '0;
            ped_pending  <= '0;
            flash_on     <= 1'b0;
            walk_en      <= 1'b0;
        end else begin
            state        <= state_nx;
            active_phase <= active_nx;
            next_phase   <= next_nx;
            // A request arriving on the entry cycle survives the clear.
            ped_pending  <= (ped_pending & ~ped_clr) | ctl.ped_req;
            if (entering_green) begin
                walk_en <= |(ped_pending & ped_clr);
            end
            if (state_nx != state) begin
                prescaler <= '0;
                timer     <= '0;
            end else if (tick) begin
                prescaler <= '0;
                // Green saturates one past its duration so rest also ends WALK.
                if (state == ST_GREEN) begin
                    if (timer != TIMER_W'(GREEN_TICKS)) begin
                        timer <= timer + 1'b1;
                    end
                end else if (state != ST_FLASH) begin
                    timer <= timer + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (state_nx == ST_FLASH && state != ST_FLASH) begin
                flash_on <= 1'b0;
            end else if (state == ST_FLASH && tick) begin
                flash_on <= ~flash_on;
            end
        end
    end

    always_comb begin
        ctl.red      = '1;
        ctl.yellow   = '0;
        ctl.green    = '0;
        ctl.ped_walk = '0;
        case (state)
            ST_GREEN: begin
                ctl.green = phase_oh;
                ctl.red   = ~phase_oh;
                if (walk_en && timer < TIMER_W'(WALK_TICKS)) begin
                    ctl.ped_walk = phase_oh;
                end
            end
            ST_YELLOW: begin
                ctl.yellow = phase_oh;
                ctl.red    = ~phase_oh;
            end
            ST_FLASH: ctl.red = {NUM_PHASES{flash_on}};
            default:  ctl.red = '1;
        endcase
    end

    assign ctl.active_phase = active_phase;
    assign ctl.in_flash     = (state == ST_FLASH);
endmodule

// File: tb/tb_signal_phase_controller.sv
// Directed-vector bench for signal_phase_controller with 3 phases and TICK_DIV=2,
// so every interval is twice its tick count in clock cycles.
module tb_signal_phase_controller;
    localparam int K_AR = 0;
    localparam int K_G  = 1;
    localparam int K_Y  = 2;
    localparam int K_FL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    signal_phase_controller_if #(.NUM_PHASES(3)) bus ();

    signal_phase_controller #(
        .NUM_PHASES  (3),
        .TICK_DIV    (2),
        .GREEN_TICKS (4),
        .YELLOW_TICKS(2),
        .ALLRED_TICKS(1),
        .WALK_TICKS  (2),
        .TIMER_W     (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {red, yellow, green}; c is the cycle within the segment.
    function automatic logic [8:0] lamps(int kind, int p, int c);
        logic [2:0] oh;
        oh = 3'b001 << p;
        case (kind)
            K_G:     return {~oh, 3'b000, oh};
            K_Y:     return {~oh, oh, 3'b000};
            K_FL:    return {(((c / 2) % 2) != 0) ? 3'b111 : 3'b000, 6'b0};
            default: return {3'b111, 6'b0};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flash_req = 1'b0;
        bus.veh_present = '0;
        bus.ped_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        vectors++;
        if ({bus.red, bus.yellow, bus.green, bus.ped_walk} !== {3'b111, 9'b0}) begin
            miscompares++;
            $display("FAIL reset_lamps got %b want %b", {bus.red, bus.yellow, bus.green, bus.ped_walk}, {3'b111, 9'b0});
        end
        vectors++;
        if ({bus.active_phase, bus.in_flash} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_status got %b want 0000", {bus.active_phase, bus.in_flash});
        end
        rst = 1'b0;
    endtask

    task automatic test_rotate();
        int sk[11] = '{K_AR, K_G, K_Y, K_AR, K_G, K_Y, K_AR, K_G, K_Y, K_AR, K_G};
        int sp[11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
        int sl[11] = '{2, 8, 4, 2, 8, 4, 2, 8, 4, 2, 8};
        int n = 0;
        logic [8:0] exp;
        do_reset();
        bus.veh_present = 3'b111;
        for (int s = 0; s < 11; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp) begin
                    miscompares++;
                    $display("FAIL rotate_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                vectors++;
                if (bus.active_phase !== 3'(sp[s])) begin
                    miscompares++;
                    $display("FAIL rotate_phase n=%0d got %0d want %0d", n, bus.active_phase, sp[s]);
                end
                vectors++;
                if (((bus.red & bus.yellow) | (bus.red & bus.green) | (bus.yellow & bus.green)
                     | ~(bus.red | bus.yellow | bus.green)) !== 3'b000 || $countones(bus.green) > 1) begin
                    miscompares++;
                    $display("FAIL rotate_onehot n=%0d got r%b y%b g%b want one lamp per phase", n, bus.red, bus.yellow, bus.green);
                end
                step();
                n++;
            end
        end
    endtask

    task automatic test_skip();
        int sk[8] = '{K_AR, K_G, K_Y, K_AR, K_G, K_Y, K_AR, K_G};
        int sp[8] = '{0, 0, 0, 0, 2, 2, 2, 0};
        int sl[8] = '{2, 8, 4, 2, 8, 4, 2, 8};
        int n = 0;
        logic [8:0] exp;
        do_reset();
        bus.veh_present = 3'b101;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp || bus.green[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL skip_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                step();
                n++;
            end
        end
    endtask

    task automatic test_rest();
        int sk[5] = '{K_AR, K_G, K_Y, K_AR, K_G};
        int sp[5] = '{0, 0, 0, 0, 1};
        int sl[5] = '{2, 18, 4, 2, 12};
        int n = 0;
        logic [8:0] exp;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp) begin
                    miscompares++;
                    $display("FAIL rest_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                // One-cycle detect pulse covering the tick cycle of the rest interval.
                bus.veh_present = (n == 19) ? 3'b010 : 3'b000;
                step();
                n++;
            end
        end
    endtask

    task automatic test_ped();
        int sk[5] = '{K_AR, K_G, K_Y, K_AR, K_G};
        int sp[5] = '{0, 0, 0, 0, 2};
        int sl[5] = '{2, 8, 4, 2, 12};
        int n = 0;
        logic [8:0] exp;
        logic [2:0] exp_walk;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                exp_walk = (s == 4 && c < 4) ? 3'b100 : 3'b000;
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp) begin
                    miscompares++;
                    $display("FAIL ped_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                vectors++;
                if (bus.ped_walk !== exp_walk) begin
                    miscompares++;
                    $display("FAIL ped_walk n=%0d got %b want %b", n, bus.ped_walk, exp_walk);
                end
                bus.ped_req = (n == 4) ? 3'b100 : 3'b000;
                step();
                n++;
            end
        end
        vectors++;
        if (dut.ped_pending !== 3'b000) begin
            miscompares++;
            $display("FAIL ped_pending_cleared got %b want 000", dut.ped_pending);
        end
    endtask

    task automatic test_flash();
        int sk[10] = '{K_AR, K_G, K_Y, K_AR, K_G, K_Y, K_AR, K_FL, K_AR, K_G};
        int sp[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        int sl[10] = '{2, 8, 4, 2, 4, 4, 2, 8, 2, 4};
        int n = 0;
        logic [8:0] exp;
        do_reset();
        bus.veh_present = 3'b111;
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp) begin
                    miscompares++;
                    $display("FAIL flash_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                vectors++;
                if (bus.in_flash !== (sk[s] == K_FL) || bus.active_phase !== 3'(sp[s])) begin
                    miscompares++;
                    $display("FAIL flash_status n=%0d got flash=%b phase=%0d want flash=%b phase=%0d",
                             n, bus.in_flash, bus.active_phase, (sk[s] == K_FL), sp[s]);
                end
                bus.flash_req = (n >= 18 && n <= 32);
                step();
                n++;
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        int sk[9] = '{K_AR, K_G, K_Y, K_AR, K_G, K_Y, K_AR, K_G, K_Y};
        int sp[9] = '{0, 0, 0, 0, 1, 1, 1, 2, 2};
        int sl[9] = '{2, 8, 4, 2, 8, 4, 2, 8, 2};
        int n = 0;
        logic [8:0] exp;
        do_reset();
        bus.veh_present = 3'b111;
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < sl[s]; c++) begin
                exp = lamps(sk[s], sp[s], c);
                vectors++;
                if ({bus.red, bus.yellow, bus.green} !== exp) begin
                    miscompares++;
                    $display("FAIL midrst_lamps n=%0d got %b want %b", n, {bus.red, bus.yellow, bus.green}, exp);
                end
                if (n == 39) begin
                    vectors++;
                    if (dut.ped_pending !== 3'b011) begin
                        miscompares++;
                        $display("FAIL midrst_pending_set got %b want 011", dut.ped_pending);
                    end
                    rst = 1'b1;
                end
                bus.ped_req = (n == 35) ? 3'b011 : 3'b000;
                step();
                n++;
            end
        end
        vectors++;
        if ({bus.red, bus.yellow, bus.green, bus.ped_walk} !== {3'b111, 9'b0}) begin
            miscompares++;
            $display("FAIL midrst_lamps_after got %b want %b", {bus.red, bus.yellow, bus.green, bus.ped_walk}, {3'b111, 9'b0});
        end
        vectors++;
        if ({bus.active_phase, bus.in_flash, dut.ped_pending} !== 7'b0) begin
            miscompares++;
            $display("FAIL midrst_status got phase=%0d flash=%b pending=%b want 0 0 000",
                     bus.active_phase, bus.in_flash, dut.ped_pending);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_skip();
        test_rest();
        test_ped();
        test_flash();
        test_reset_mid_yellow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/signal_phase_controller.md
Name: signal_phase_controller

Overview:
Parametrised N-phase traffic signal controller, successor to the fixed two-direction NS/EW controller. It cycles through NUM_PHASES approaches, each with green, yellow and all-red clearance intervals. It adds:
- demand-driven phase skipping (vehicle detect and latched pedestrian calls),
- rest-in-green when no other approach has demand,
- pedestrian WALK outputs,
- a safe red-flash mode.

It sits between the detector/push-button synchronisers and the lamp drivers.

Parameters:
NUM_PHASES, 4, number of approaches; legal range 2..8.
TICK_DIV, 100000000, clk cycles per timing tick; must be >=1.
GREEN_TICKS, 10, green duration in ticks; must be >=1.
YELLOW_TICKS, 3, yellow duration in ticks; must be >=1.
ALLRED_TICKS, 1, all-red clearance in ticks; must be >=1.
WALK_TICKS, 5, WALK duration at the start of a served green; must be >=1 and <=GREEN_TICKS.
TIMER_W, 32, width of the prescaler and tick timer; all tick parameters and TICK_DIV must fit.

Ports:
clk  in  1  system clock
rst  in  1  reset
flash_req  in  1  level; request red-flash mode
veh_present  in  NUM_PHASES  level vehicle detect per phase, already synchronised
ped_req  in  NUM_PHASES  pedestrian button per phase, already synchronised; a high level sets the latch
red  out  NUM_PHASES  red lamp per phase
yellow  out  NUM_PHASES  yellow lamp per phase
green  out  NUM_PHASES  green lamp per phase
ped_walk  out  NUM_PHASES  WALK indication per phase
active_phase  out  3  index of the phase currently green, yellow, or last cleared
in_flash  out  1  high while in FLASH state

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- Reset mid-operation takes effect at the next clk edge, from any state.

Reset values:
- state=ALL_RED, active_phase=0, next_phase=0, prescaler=0, timer=0, ped_pending=0, flash_on=0.
- Outputs: red=all ones, yellow=0, green=0, ped_walk=0, in_flash=0.

Timing:
- Prescaler counts 0..TICK_DIV-1; a tick fires when prescaler==TICK_DIV-1.
- Prescaler and timer both clear on every state transition.
- A state of duration D ticks therefore lasts exactly D*TICK_DIV cycles.
- Outputs are a combinational decode of registered state, with zero added latency.

States:
- GREEN(p): green[p]=1, all other red=1.
- YELLOW(p): yellow[p]=1, all other red=1.
- ALL_RED: red=all ones.
- FLASH: red=flash_on replicated on every bit, yellow=green=0; flash_on toggles on every tick.
- Exactly one of red/yellow/green is high per phase in every non-FLASH state.

Demand:
- demand[i] = veh_present[i] | ped_pending[i].
- ped_pending[i] sets on ped_req[i]=1.
- ped_pending[i] clears on the cycle GREEN(i) is entered; set takes priority if ped_req[i] is high that same cycle.

Transitions:
- ALL_RED → GREEN(next_phase) at the end of ALLRED_TICKS, when flash_req=0.
- ALL_RED → FLASH at the end of ALLRED_TICKS, when flash_req=1.
- GREEN(p), at the end of GREEN_TICKS, searches for the first i with demand[i]=1, scanning from (p+1) mod N round-robin and excluding p:
  - If found: next_phase=i, go to YELLOW(p).
  - If none: remain in GREEN(p) (rest). Timer saturates; re-evaluate on every tick.
- GREEN(p) with flash_req=1: go to YELLOW(p) on the next tick regardless of elapsed time; next_phase is unchanged.
- YELLOW(p) → ALL_RED after YELLOW_TICKS; active_phase keeps p.
- FLASH with flash_req=0: go to ALL_RED with next_phase=0. ped_pending is preserved.
- Demand that disappears during YELLOW or ALL_RED does not cancel the selected next_phase.

Pedestrian WALK:
- ped_walk[p]=1 during the first WALK_TICKS ticks of GREEN(p), only if ped_pending[p] was set at GREEN entry; otherwise 0.
- A ped_req for the currently green phase stays latched for its next service.
- That latched request does not count as demand for leaving the current phase.

Boundaries:
- With TICK_DIV=1, a tick fires every cycle.
- active_phase is zero-extended when NUM_PHASES<8.

Test Plan:
Common parameters for all scenarios: NUM_PHASES=3, TICK_DIV=2, GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1, WALK_TICKS=2.

1. Reset release, veh_present=3'b111 → ALL_RED 2 cycles, GREEN(0) 8 cycles, YELLOW(0) 4, ALL_RED 2, GREEN(1), then GREEN(2), GREEN(0). Every cycle: exactly one of r/y/g set per phase; green never on two phases at once.
2. Skip: veh_present=3'b101 → sequence GREEN(0), YELLOW(0), ALL_RED, GREEN(2), …, GREEN(0); phase 1 is never green.
3. Rest: veh_present=0, no ped_req → GREEN(0) holds indefinitely. Pulse veh_present[1] for 1 cycle → at the next tick, YELLOW(0) then GREEN(1), even though detect has dropped.
4. Pedestrian: 1-cycle ped_req[2] pulse during GREEN(0), no vehicles → GREEN(2) is served. ped_walk[2] is high for the first 4 cycles of GREEN(2), then low; ped_pending[2] is cleared.
5. Flash: flash_req=1 mid-GREEN(1) → YELLOW(1) starts within 2 cycles, then ALL_RED, then FLASH with red toggling 3'b000/3'b111 every 2 cycles. flash_req=0 → ALL_RED 2 cycles, then GREEN(0).
6. Reset mid-YELLOW(2) with ped_pending set → the next cycle matches the reset values exactly; ped_walk=0 and ped_pending=0.
